// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
// Shared definitions for the multi-lane instruction queue and any block that
// reuses its lane packing (e.g. the reservation-station write path).
//   FLD_*        field index of type/dest/src1/src0 inside one instruction;
//                field k occupies bits [(k+1)*IPW-1 -: IPW]
//   MAX_LANES    widest lane vector the helper functions accept
//   f_popcount   number of set bits in a lane vector
//   f_is_thermo  1 when the set bits form a contiguous run starting at bit 0
package inst_queue_pkg;

    localparam int FLD_TYPE  = 3;
    localparam int FLD_DEST  = 2;
    localparam int FLD_SRC1  = 1;
    localparam int FLD_SRC0  = 0;
    localparam int MAX_LANES = 4;

    function automatic logic [2:0] f_popcount(input logic [MAX_LANES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic f_is_thermo(input logic [MAX_LANES-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < MAX_LANES; i++) begin
            if (v[i] && !v[i-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_queue_mp_if.sv
// inst_queue_mp_if
// Fetch-side / IDU-side bus of the multi-lane instruction queue.
//   flush      master->slave  drop all entries
//   wr_inst    master->slave  NUM_LANES instructions, lane i at [i*IW +: IW]
//   wr_val     master->slave  per-lane write valid
//   wr_rdy     slave->master  queue can take a full NUM_LANES write
//   rd_fetch   master->slave  per-lane pop request (thermometer from lane 0)
//   rd_valid   slave->master  lane i holds a valid instruction
//   rd_type/rd_dest/rd_src1/rd_src0  slave->master  per-lane fields
//   count      slave->master  occupancy 0..QUEUE_DEPTH
// Parameters must match those of the inst_queue_mp instance it connects to.
interface inst_queue_mp_if #(
    parameter int INS_PART_WID = 4,
    parameter int NUM_LANES    = 2,
    parameter int QUEUE_DEPTH  = 32
);
    localparam int INS_WID = 4 * INS_PART_WID;
    localparam int CNT_WID = $clog2(QUEUE_DEPTH) + 1;

    logic                              flush;
    logic [NUM_LANES*INS_WID-1:0]      wr_inst;
    logic [NUM_LANES-1:0]              wr_val;
    logic                              wr_rdy;
    logic [NUM_LANES-1:0]              rd_fetch;
    logic [NUM_LANES-1:0]              rd_valid;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_type;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_dest;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_src1;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_src0;
    logic [CNT_WID-1:0]                count;

    modport master (
        output flush, wr_inst, wr_val, rd_fetch,
        input  wr_rdy, rd_valid, rd_type, rd_dest, rd_src1, rd_src0, count
    );

    modport slave (
        input  flush, wr_inst, wr_val, rd_fetch,
        output wr_rdy, rd_valid, rd_type, rd_dest, rd_src1, rd_src0, count
    );

endinterface

// File: rtl/inst_lane_pack.sv
// inst_lane_pack
// Combinational compaction of a sparse multi-lane write into a dense vector:
// valid lanes are moved, in lane order, to the lowest packed positions.
//   wr_inst      in   NUM_LANES*INS_WID  raw lanes
//   wr_val       in   NUM_LANES          per-lane valid
//   pack_inst    out  NUM_LANES*INS_WID  dense lanes; unused positions are 0
//   nwr          out  3                  number of valid lanes
module inst_lane_pack
    import inst_queue_pkg::*;
#(
    parameter int INS_WID   = 16,
    parameter int NUM_LANES = 2
) (
    input  logic [NUM_LANES*INS_WID-1:0] wr_inst,
    input  logic [NUM_LANES-1:0]         wr_val,
    output logic [NUM_LANES*INS_WID-1:0] pack_inst,
    output logic [2:0]                   nwr
);

    logic [2:0] slot;

    always_comb begin
        pack_inst = '0;
        slot      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_val[i]) begin
                pack_inst[slot*INS_WID +: INS_WID] = wr_inst[i*INS_WID +: INS_WID];
                slot = slot + 3'd1;
            end
        end
    end

    assign nwr = f_popcount(MAX_LANES'(wr_val));

endmodule

// File: rtl/inst_queue_mp.sv
// inst_queue_mp
// Multi-lane FIFO between fetch and the IDU. Lane 0 is always the oldest
// instruction. Writes are all-or-nothing, reads are first-word-fall-through.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset (priority over flush)
//   bus   slave modport of inst_queue_mp_if (write lanes, read lanes, count)
module inst_queue_mp
    import inst_queue_pkg::*;
#(
    parameter int INS_PART_WID = 4,
    parameter int QUEUE_DEPTH  = 32,
    parameter int NUM_LANES    = 2
) (
    input  logic           clk,
    input  logic           rst,
    inst_queue_mp_if.slave bus
);

    localparam int PTR_WIDTH = $clog2(QUEUE_DEPTH);
    localparam int INS_WID   = 4 * INS_PART_WID;
    localparam int CNT_WID   = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0]             wr_ptr;
    logic [PTR_WIDTH-1:0]             rd_ptr;
    logic [CNT_WID-1:0]               count_q;
    logic [INS_WID-1:0]               mem [QUEUE_DEPTH];

    logic [NUM_LANES*INS_WID-1:0]     pack_inst;
    logic [2:0]                       nwr_raw;
    logic [2:0]                       nwr;
    logic [2:0]                       nrd;
    logic                             wr_rdy;

    logic [NUM_LANES-1:0]             rd_valid;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_type;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_dest;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_src1;
    logic [NUM_LANES*INS_PART_WID-1:0] rd_src0;
    logic [PTR_WIDTH-1:0]             rd_addr;
    logic [INS_WID-1:0]               entry;
    logic                             run;

    inst_lane_pack #(
        .INS_WID   (INS_WID),
        .NUM_LANES (NUM_LANES)
    ) u_lane_pack (
        .wr_inst   (bus.wr_inst),
        .wr_val    (bus.wr_val),
        .pack_inst (pack_inst),
        .nwr       (nwr_raw)
    );

    // Registered count only: no combinational path from rd_fetch to wr_rdy.
    assign wr_rdy = (CNT_WID'(QUEUE_DEPTH) - count_q) >= CNT_WID'(NUM_LANES);
    assign nwr    = wr_rdy ? nwr_raw : 3'd0;

    // Read side. nrd counts only the contiguous run of fetched, valid lanes
    // from lane 0, so a gap in rd_fetch stops the pop at the gap.
    always_comb begin
        rd_valid = '0;
        rd_type  = '0;
        rd_dest  = '0;
        rd_src1  = '0;
        rd_src0  = '0;
        rd_addr  = '0;
        entry    = '0;
        nrd      = '0;
        run      = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_valid[i] = count_q > CNT_WID'(i);
            run         = run & bus.rd_fetch[i] & rd_valid[i];
            if (run) begin
                nrd = nrd + 3'd1;
            end
            rd_addr = rd_ptr + PTR_WIDTH'(i);
            if (rd_valid[i]) begin
                entry = mem[rd_addr];
                rd_type[i*INS_PART_WID +: INS_PART_WID] = entry[FLD_TYPE*INS_PART_WID +: INS_PART_WID];
                rd_dest[i*INS_PART_WID +: INS_PART_WID] = entry[FLD_DEST*INS_PART_WID +: INS_PART_WID];
                rd_src1[i*INS_PART_WID +: INS_PART_WID] = entry[FLD_SRC1*INS_PART_WID +: INS_PART_WID];
                rd_src0[i*INS_PART_WID +: INS_PART_WID] = entry[FLD_SRC0*INS_PART_WID +: INS_PART_WID];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_WIDTH'(nwr);
            rd_ptr  <= rd_ptr + PTR_WIDTH'(nrd);
            count_q <= count_q + CNT_WID'(nwr) - CNT_WID'(nrd);
        end
    end

    // Storage is not reset; pointer arithmetic wraps naturally at QUEUE_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (3'(i) < nwr) begin
                    mem[wr_ptr + PTR_WIDTH'(i)] <= pack_inst[i*INS_WID +: INS_WID];
                end
            end
        end
    end

    assign bus.wr_rdy   = wr_rdy;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_type  = rd_type;
    assign bus.rd_dest  = rd_dest;
    assign bus.rd_src1  = rd_src1;
    assign bus.rd_src0  = rd_src0;
    assign bus.count    = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            a_count_max : assert (count_q <= CNT_WID'(QUEUE_DEPTH));
            a_no_wr_full: assert (wr_rdy || nwr == 3'd0);
            a_thermo    : assert (f_is_thermo(MAX_LANES'(bus.rd_fetch)));
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue_mp.sv
module tb_inst_queue_mp;

    localparam int IPW = 4;
    localparam int NL  = 2;
    localparam int QD  = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inst_queue_mp_if #(.INS_PART_WID(IPW), .NUM_LANES(NL), .QUEUE_DEPTH(QD)) bus ();

    inst_queue_mp #(
        .INS_PART_WID (IPW),
        .QUEUE_DEPTH  (QD),
        .NUM_LANES    (NL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] sb [$];

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  wr_val;
        logic [15:0] l0;
        logic [15:0] l1;
        logic [1:0]  fetch;
        logic [5:0]  e_count;
        logic [1:0]  e_valid;
        logic        e_rdy;
        logic [15:0] e_l0;
        logic [15:0] e_l1;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(logic r, logic f, logic [1:0] v, logic [15:0] l0, logic [15:0] l1,
                                logic [1:0] fe, logic [5:0] ec, logic [1:0] ev, logic er,
                                logic [15:0] e0, logic [15:0] e1);
        vec_t t;
        t.rst = r; t.flush = f; t.wr_val = v; t.l0 = l0; t.l1 = l1; t.fetch = fe;
        t.e_count = ec; t.e_valid = ev; t.e_rdy = er; t.e_l0 = e0; t.e_l1 = e1;
        return t;
    endfunction

    function automatic logic [15:0] lane(int i);
        return {bus.rd_type[i*IPW +: IPW], bus.rd_dest[i*IPW +: IPW],
                bus.rd_src1[i*IPW +: IPW], bus.rd_src0[i*IPW +: IPW]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic [1:0] v, logic [15:0] l0, logic [15:0] l1, logic [1:0] fe);
        rst          = r;
        bus.flush    = f;
        bus.wr_val   = v;
        bus.wr_inst  = {l1, l0};
        bus.rd_fetch = fe;
    endtask

    task automatic check_state(string tag, logic [5:0] ec, logic [1:0] ev, logic er,
                               logic [15:0] e0, logic [15:0] e1);
        chk({tag, "_count"}, 32'(bus.count), 32'(ec));
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'(ev));
        chk({tag, "_rdy"}, 32'(bus.wr_rdy), 32'(er));
        chk({tag, "_lane0"}, 32'(lane(0)), 32'(e0));
        chk({tag, "_lane1"}, 32'(lane(1)), 32'(e1));
    endtask

    task automatic model_check(string tag);
        int sz;
        sz = sb.size();
        check_state(tag, 6'(sz), {sz > 1, sz > 0}, (QD - sz) >= NL,
                    (sz > 0) ? sb[0] : 16'h0, (sz > 1) ? sb[1] : 16'h0);
    endtask

    // One clocked step against the reference queue; call at a negedge.
    task automatic mstep(logic f, logic [1:0] v, logic [15:0] l0, logic [15:0] l1,
                         logic [1:0] fe, string tag);
        int sz;
        int nrd;
        drive(1'b0, f, v, l0, l1, fe);
        sz = sb.size();
        @(posedge clk);
        if (f) begin
            sb.delete();
        end else begin
            nrd = 0;
            if (fe[0] && sz > 0) begin
                nrd = 1;
                if (fe[1] && sz > 1) nrd = 2;
            end
            for (int k = 0; k < nrd; k++) void'(sb.pop_front());
            if ((QD - sz) >= NL) begin
                if (v[0]) sb.push_back(l0);
                if (v[1]) sb.push_back(l1);
            end
        end
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]  rv;
        logic [1:0]  rf;
        int          r;

        tbl[0]  = mk(0, 0, 2'b00, 16'h0000, 16'h0000, 2'b00, 6'd0, 2'b00, 1, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 0, 2'b01, 16'h1234, 16'h0000, 2'b00, 6'd1, 2'b01, 1, 16'h1234, 16'h0000);
        tbl[2]  = mk(0, 0, 2'b00, 16'h0000, 16'h0000, 2'b01, 6'd0, 2'b00, 1, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 0, 2'b10, 16'h5555, 16'hABCD, 2'b00, 6'd1, 2'b01, 1, 16'hABCD, 16'h0000);
        tbl[4]  = mk(0, 0, 2'b11, 16'h1111, 16'h2222, 2'b01, 6'd2, 2'b11, 1, 16'h1111, 16'h2222);
        tbl[5]  = mk(0, 0, 2'b01, 16'h3333, 16'h0000, 2'b11, 6'd1, 2'b01, 1, 16'h3333, 16'h0000);
        tbl[6]  = mk(0, 0, 2'b00, 16'h0000, 16'h0000, 2'b11, 6'd0, 2'b00, 1, 16'h0000, 16'h0000);
        tbl[7]  = mk(0, 0, 2'b11, 16'h4444, 16'h5555, 2'b00, 6'd2, 2'b11, 1, 16'h4444, 16'h5555);
        tbl[8]  = mk(0, 1, 2'b11, 16'h6666, 16'h7777, 2'b11, 6'd0, 2'b00, 1, 16'h0000, 16'h0000);
        tbl[9]  = mk(0, 0, 2'b01, 16'h8888, 16'h0000, 2'b00, 6'd1, 2'b01, 1, 16'h8888, 16'h0000);
        tbl[10] = mk(1, 1, 2'b11, 16'hC0C0, 16'hD0D0, 2'b01, 6'd0, 2'b00, 1, 16'h0000, 16'h0000);
        tbl[11] = mk(0, 0, 2'b11, 16'h9999, 16'hAAAA, 2'b00, 6'd2, 2'b11, 1, 16'h9999, 16'hAAAA);

        @(negedge clk);
        do_reset();
        check_state("reset", 6'd0, 2'b00, 1'b1, 16'h0, 16'h0);

        // Directed table: inputs for one edge, state expected after it.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].wr_val, tbl[i].l0, tbl[i].l1, tbl[i].fetch);
            @(posedge clk);
            @(negedge clk);
            check_state($sformatf("vec%0d", i), tbl[i].e_count, tbl[i].e_valid, tbl[i].e_rdy,
                        tbl[i].e_l0, tbl[i].e_l1);
        end
        chk("vec1_fields", 32'(tbl[1].e_l0), 32'h1234);

        // Fill to the high-water marks, dropped writes, simultaneous r/w at full.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            mstep(0, 2'b11, 16'h0100 + 16'(2*k), 16'h0100 + 16'(2*k+1), 2'b00, "fill");
        end
        chk("c30_rdy", 32'(bus.wr_rdy), 32'd1);
        mstep(0, 2'b01, 16'h011E, 16'h0000, 2'b00, "to31");
        chk("c31_rdy", 32'(bus.wr_rdy), 32'd0);
        mstep(0, 2'b11, 16'hDEAD, 16'hBEEF, 2'b00, "drop31");
        chk("c31_count", 32'(bus.count), 32'd31);
        mstep(0, 2'b00, 16'h0000, 16'h0000, 2'b01, "pop1");
        mstep(0, 2'b11, 16'h011F, 16'h0120, 2'b00, "to32");
        chk("c32_rdy", 32'(bus.wr_rdy), 32'd0);
        mstep(0, 2'b11, 16'hBAD0, 16'hBAD1, 2'b00, "drop32");
        chk("c32_count", 32'(bus.count), 32'd32);
        chk("c32_head", 32'(lane(0)), 32'h0101);
        mstep(0, 2'b11, 16'hBAD2, 16'hBAD3, 2'b11, "rw_full");
        chk("rw_full_count", 32'(bus.count), 32'd30);
        for (int k = 0; k < 16; k++) begin
            mstep(0, 2'b00, 16'h0, 16'h0, 2'b11, "drain");
        end
        chk("drain_empty", 32'(bus.count), 32'd0);

        // Random traffic against the reference queue; pointers wrap many times.
        for (int c = 0; c < 200; c++) begin
            rv = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 2));
            rf = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            mstep(0, rv, 16'($urandom), 16'($urandom), rf, "rand");
        end

        // Flush together with a write and a fetch.
        mstep(0, 2'b11, 16'hF001, 16'hF002, 2'b00, "pre_flush");
        mstep(1, 2'b11, 16'hF003, 16'hF004, 2'b11, "flush");
        chk("flush_count", 32'(bus.count), 32'd0);
        mstep(0, 2'b01, 16'hE001, 16'h0000, 2'b00, "post_flush");

        // rst and flush together: reset state, first write lands visibly next cycle.
        drive(1'b1, 1'b1, 2'b11, 16'hE002, 16'hE003, 2'b01);
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        check_state("rst_flush", 6'd0, 2'b00, 1'b1, 16'h0, 16'h0);
        mstep(0, 2'b11, 16'h7A01, 16'h7A02, 2'b00, "after_rst");
        mstep(0, 2'b00, 16'h0, 16'h0, 2'b01, "after_rst_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
